// File: rtl/omult_pkg.sv
// Shared definitions for the online-multiplier sequencing controller.
package omult_pkg;

    localparam int unsigned N_DIGITS_DEF = 16;
    localparam int unsigned DELTA_DEF    = 3;
    localparam int unsigned ADDR_W_DEF   = 9;

    typedef enum logic [2:0] {
        IDLE,
        WARMUP,
        RUN,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/omult_step_cnt.sv
// Step counter: synchronous clear has priority over count enable.
module omult_step_cnt #(
    parameter int unsigned W = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/omult_seq_ctrl.sv
// Sequencing controller for an online multiplier: walks operand reads,
// delayed result writes and a zero-fed flush, then pulses done.
module omult_seq_ctrl
    import omult_pkg::*;
#(
    parameter int unsigned N_DIGITS = N_DIGITS_DEF,
    parameter int unsigned DELTA    = DELTA_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              in_rd_en,
    output logic [ADDR_W-1:0] in_addr,
    output logic              zero_in,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done
);

    localparam longint unsigned SPAN = 64'(N_DIGITS) + 64'(DELTA);
    localparam longint unsigned CAP  = 64'(1) << ADDR_W;

    if (DELTA < 1 || DELTA >= N_DIGITS || ADDR_W > 32 || SPAN > CAP) begin : g_param_err
        $error("omult_seq_ctrl: illegal N_DIGITS/DELTA/ADDR_W combination");
    end

    localparam logic [ADDR_W-1:0] LAST_WARM = ADDR_W'(DELTA - 1);
    localparam logic [ADDR_W-1:0] LAST_RUN  = ADDR_W'(N_DIGITS - 1);
    localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(N_DIGITS + DELTA - 1);
    localparam logic [ADDR_W-1:0] DELTA_A   = ADDR_W'(DELTA);

    state_t            state;
    logic [ADDR_W-1:0] step;
    logic              active;
    logic              advance;
    logic              flush_last;

    assign active     = (state == WARMUP) || (state == RUN) || (state == FLUSH);
    assign advance    = active && !stall;
    assign flush_last = (state == FLUSH) && advance && (step == LAST_STEP);

    // Step is held at 0 outside the active window so a new run always starts at 0.
    omult_step_cnt #(
        .W (ADDR_W)
    ) u_step_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (!active || flush_last),
        .en    (advance),
        .count (step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= WARMUP;
                WARMUP:  if (advance && step == LAST_WARM) state <= RUN;
                RUN:     if (advance && step == LAST_RUN) state <= FLUSH;
                FLUSH:   if (flush_last) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Decodes of registered state/step; stall only masks the enables.
    assign busy      = (state != IDLE);
    assign in_rd_en  = ((state == WARMUP) || (state == RUN)) && !stall;
    assign in_addr   = step;
    assign zero_in   = (state == FLUSH);
    assign out_wr_en = ((state == RUN) || (state == FLUSH)) && !stall;
    assign out_addr  = (state == IDLE) ? '0 : ADDR_W'(step - DELTA_A);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_omult_seq_ctrl.sv
// Directed bench for omult_seq_ctrl: nominal, stall, ignored start, reset,
// back-to-back and minimal-parameter runs.
module tb_omult_seq_ctrl;

    localparam int unsigned AW  = 9;
    localparam int unsigned AWM = 3;
    localparam int          ND  = 16;
    localparam int          DL  = 3;

    logic          clk = 1'b0;
    logic          rst, start, stall, start_m, stall_m;
    logic          busy, in_rd_en, zero_in, out_wr_en, done;
    logic [AW-1:0] in_addr, out_addr;
    logic          busy_m, in_rd_en_m, zero_in_m, out_wr_en_m, done_m;
    logic [AWM-1:0] in_addr_m, out_addr_m;
    logic [4:0]    fl, fl_m;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    assign fl   = {busy, in_rd_en, zero_in, out_wr_en, done};
    assign fl_m = {busy_m, in_rd_en_m, zero_in_m, out_wr_en_m, done_m};

    omult_seq_ctrl #(.N_DIGITS(16), .DELTA(3), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .busy(busy), .in_rd_en(in_rd_en), .in_addr(in_addr), .zero_in(zero_in),
        .out_wr_en(out_wr_en), .out_addr(out_addr), .done(done)
    );

    omult_seq_ctrl #(.N_DIGITS(2), .DELTA(1), .ADDR_W(AWM)) dut_min (
        .clk(clk), .rst(rst), .start(start_m), .stall(stall_m),
        .busy(busy_m), .in_rd_en(in_rd_en_m), .in_addr(in_addr_m), .zero_in(zero_in_m),
        .out_wr_en(out_wr_en_m), .out_addr(out_addr_m), .done(done_m)
    );

    // Drive point: just after a rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (fl !== 5'b0) $display("FAIL reset_flags got %b exp 00000", fl); else passed++;
        checks++; if (in_addr !== '0 || out_addr !== '0) $display("FAIL reset_addr got %0d/%0d exp 0/0", in_addr, out_addr); else passed++;
        checks++; if (fl_m !== 5'b0) $display("FAIL reset_flags_min got %b exp 00000", fl_m); else passed++;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_nominal(input string tag);
        logic [4:0] e;
        int s;
        start = 1'b1; stall = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) $display("FAIL %s_idle busy got %b exp 0", tag, busy); else passed++;
        next_cycle();
        start = 1'b0;
        for (int k = 1; k <= ND + DL + 2; k++) begin
            s = k - 1;
            @(negedge clk);
            if (k <= ND + DL) e = {1'b1, s < ND, s >= ND, s >= DL, 1'b0};
            else if (k == ND + DL + 1) e = 5'b10001;
            else e = 5'b00000;
            checks++; if (fl !== e) $display("FAIL %s k=%0d flags got %b exp %b", tag, k, fl, e); else passed++;
            if (e[3]) begin
                checks++; if (in_addr !== AW'(s)) $display("FAIL %s k=%0d in_addr got %0d exp %0d", tag, k, in_addr, s); else passed++;
            end
            if (e[1]) begin
                checks++; if (out_addr !== AW'(s - DL)) $display("FAIL %s k=%0d out_addr got %0d exp %0d", tag, k, out_addr, s - DL); else passed++;
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        logic [4:0] e;
        int es, nin, nout, done_k;
        logic act;
        es = 0; nin = 0; nout = 0; done_k = -1;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            stall = (k >= 9 && k <= 12);
            act = (es <= ND + DL - 1);
            @(negedge clk);
            if (act) e = {1'b1, (es < ND) && !stall, es >= ND, (es >= DL) && !stall, 1'b0};
            else if (es == ND + DL) e = 5'b10001;
            else e = 5'b00000;
            checks++; if (fl !== e) $display("FAIL stall k=%0d flags got %b exp %b", k, fl, e); else passed++;
            if (stall) begin
                checks++; if (in_addr !== AW'(8)) $display("FAIL stall_frozen k=%0d step got %0d exp 8", k, in_addr); else passed++;
            end
            if (in_rd_en === 1'b1) begin
                checks++; if (in_addr !== AW'(nin)) $display("FAIL stall_rd_seq k=%0d got %0d exp %0d", k, in_addr, nin); else passed++;
                nin++;
            end
            if (out_wr_en === 1'b1) begin
                checks++; if (out_addr !== AW'(nout)) $display("FAIL stall_wr_seq k=%0d got %0d exp %0d", k, out_addr, nout); else passed++;
                nout++;
            end
            if (done === 1'b1) done_k = k;
            if (act && !stall) es++;
            else if (es == ND + DL) es++;
            next_cycle();
        end
        stall = 1'b0;
        checks++; if (done_k != 24) $display("FAIL stall_done_cycle got %0d exp 24", done_k); else passed++;
        checks++; if (nin != ND || nout != ND) $display("FAIL stall_counts got %0d/%0d exp 16/16", nin, nout); else passed++;
    endtask

    task automatic test_start_ignored();
        logic [4:0] e;
        int s, ndone;
        ndone = 0;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            s = k - 1;
            start = (k == 3 || k == 11 || k == 18 || k == 20);
            @(negedge clk);
            if (k <= ND + DL) e = {1'b1, s < ND, s >= ND, s >= DL, 1'b0};
            else if (k == ND + DL + 1) e = 5'b10001;
            else e = 5'b00000;
            checks++; if (fl !== e) $display("FAIL start_ign k=%0d flags got %b exp %b", k, fl, e); else passed++;
            if (e[3]) begin
                checks++; if (in_addr !== AW'(s)) $display("FAIL start_ign k=%0d in_addr got %0d exp %0d", k, in_addr, s); else passed++;
            end
            if (done === 1'b1) ndone++;
            next_cycle();
        end
        start = 1'b0;
        checks++; if (ndone != 1) $display("FAIL start_ign_done_count got %0d exp 1", ndone); else passed++;
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (12) next_cycle();
        @(negedge clk);
        checks++; if (busy !== 1'b1 || in_addr !== AW'(12)) $display("FAIL rst_mid_pre got busy=%b step=%0d exp 1/12", busy, in_addr); else passed++;
        rst = 1'b1;
        #1;
        checks++; if (fl !== 5'b0) $display("FAIL rst_mid_flags got %b exp 00000", fl); else passed++;
        checks++; if (in_addr !== '0 || out_addr !== '0) $display("FAIL rst_mid_addr got %0d/%0d exp 0/0", in_addr, out_addr); else passed++;
        next_cycle();
        rst = 1'b0;
        test_nominal("after_rst");
    endtask

    task automatic test_back_to_back();
        logic exp_busy, exp_done;
        start = 1'b1;
        next_cycle();
        for (int k = 1; k <= 42; k++) begin
            start = (k <= 40);
            @(negedge clk);
            exp_busy = !(k == 21 || k == 42);
            exp_done = (k == 20 || k == 41);
            checks++; if (busy !== exp_busy || done !== exp_done) $display("FAIL b2b k=%0d busy/done got %b%b exp %b%b", k, busy, done, exp_busy, exp_done); else passed++;
            if (k == 1 || k == 22) begin
                checks++; if (in_rd_en !== 1'b1 || in_addr !== '0) $display("FAIL b2b_first_rd k=%0d got en=%b addr=%0d exp 1/0", k, in_rd_en, in_addr); else passed++;
            end
            next_cycle();
        end
        start = 1'b0;
    endtask

    task automatic test_min();
        logic [4:0] tbl [5];
        tbl = '{5'b11000, 5'b11010, 5'b10110, 5'b10001, 5'b00000};
        start_m = 1'b1;
        next_cycle();
        start_m = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++; if (fl_m !== tbl[k-1]) $display("FAIL min k=%0d flags got %b exp %b", k, fl_m, tbl[k-1]); else passed++;
            if (tbl[k-1][3]) begin
                checks++; if (in_addr_m !== AWM'(k - 1)) $display("FAIL min k=%0d in_addr got %0d exp %0d", k, in_addr_m, k - 1); else passed++;
            end
            if (tbl[k-1][1]) begin
                checks++; if (out_addr_m !== AWM'(k - 2)) $display("FAIL min k=%0d out_addr got %0d exp %0d", k, out_addr_m, k - 2); else passed++;
            end
            next_cycle();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stall = 1'b0; start_m = 1'b0; stall_m = 1'b0;
        test_reset();
        test_nominal("nominal");
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_min();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
